// File: rtl/bin2bcd_defs.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and default geometry.
package bin2bcd_defs;

    localparam int W_DEF  = 16;
    localparam int ND_DEF = 5;

    // Digits shown on the 4-digit display; anything above is overflow.
    localparam int DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a BCD digit above 4 gets 3 added
// before the shift, so the doubled digit carries correctly into the next one.
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one bit per cycle for W cycles, then a
// single-cycle publish of the digits, which stay stable for the display mux.
module bin2bcd_seq
    import bin2bcd_defs::*;
#(
    parameter int W  = W_DEF,
    parameter int ND = ND_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            ready,
    output logic            done_tick,
    output logic [4*ND-1:0] bcd,
    output logic            ovf4
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * ND;

    state_t          state_q, state_d;
    logic [W-1:0]    sh_q, sh_d;
    logic [BW-1:0]   work_q, work_d, work_adj;
    logic [CW-1:0]   n_q, n_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf4_q, ovf4_d;
    logic            done_q, done_d;
    logic            hi_nz;

    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_adj3 u_adj (
            .digit    (work_q[4*g +: 4]),
            .adjusted (work_adj[4*g +: 4])
        );
    end

    // Any digit beyond the displayed four being nonzero means the display overflows.
    always_comb begin
        hi_nz = 1'b0;
        for (int i = 4 * DISP_DIGITS; i < BW; i++) begin
            hi_nz = hi_nz | work_q[i];
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        sh_d    = sh_q;
        work_d  = work_q;
        n_d     = n_q;
        bcd_d   = bcd_q;
        ovf4_d  = ovf4_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    work_d  = '0;
                    n_d     = CW'(W);
                    state_d = OP;
                end
            end
            OP: begin
                work_d = {work_adj[BW-2:0], sh_q[W-1]};
                sh_d   = {sh_q[W-2:0], 1'b0};
                n_d    = n_q - 1'b1;
                if (n_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = work_q;
                ovf4_d  = hi_nz;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the shift and counter registers are cleared too, so a reset mid-conversion leaves no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            work_q <= '0;
            n_q    <= '0;
            bcd_q  <= '0;
            ovf4_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            work_q <= work_d;
            n_q    <= n_d;
            bcd_q  <= bcd_d;
            ovf4_q <= ovf4_d;
            done_q <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = done_q;
    assign bcd       = bcd_q;
    assign ovf4      = ovf4_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed launches push expected digits and
// tick cycles; a negedge monitor pops and compares on every done_tick.
module tb_bin2bcd_seq;

    localparam int W  = 16;
    localparam int ND = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [W-1:0]    bin;
    logic            ready;
    logic            done_tick;
    logic [4*ND-1:0] bcd;
    logic            ovf4;

    bin2bcd_seq #(.W(W), .ND(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd       (bcd),
        .ovf4      (ovf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic            ovf4;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    int              ticks    = 0;
    int              pushed   = 0;
    logic [4*ND-1:0] held     = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares at each done_tick, and otherwise insists bcd holds its last published value.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            held = '0;
        end else if (done_tick) begin
            ticks++;
            if (sb.size() == 0) begin
                check("unexpected_done_tick", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("ovf4", 32'(ovf4), 32'(e.ovf4));
                check("tick_cycle", cyc, e.cyc);
                check("ready_at_tick", 32'(ready), 32'd1);
                held = e.bcd;
            end
        end else begin
            check("bcd_held", 32'(bcd), 32'(held));
        end
    end

    // Drives one start pulse; the following edge is the accept edge.
    task automatic launch(input logic [W-1:0] v, input logic [4*ND-1:0] eb,
                          input logic eo, input bit expect_result);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 16'hdead;
        if (expect_result) begin
            e.bcd  = eb;
            e.ovf4 = eo;
            e.cyc  = cyc + W + 1;
            sb.push_back(e);
            pushed++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          acc;
        logic [15:0] vals [2];
        logic [19:0] exps [2];

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done_tick", 32'(done_tick), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_ovf4", 32'(ovf4), 32'd0);

        launch(16'd0,     20'h00000, 1'b0, 1'b1); drain();
        launch(16'd1234,  20'h01234, 1'b0, 1'b1); drain();
        launch(16'd9999,  20'h09999, 1'b0, 1'b1); drain();
        launch(16'd10000, 20'h10000, 1'b1, 1'b1); drain();
        launch(16'd65535, 20'h65535, 1'b1, 1'b1); drain();

        // A start pulse during OP must be ignored.
        launch(16'd4321, 20'h04321, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_ready", 32'(ready), 32'd0);
        start = 1'b1;
        bin   = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // Reset five cycles into a conversion aborts it without a tick.
        launch(16'd65535, 20'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_ovf4", 32'(ovf4), 32'd0);
        check("abort_done_tick", 32'(done_tick), 32'd0);
        repeat (W + 4) @(negedge clk);
        launch(16'd42, 20'h00042, 1'b0, 1'b1); drain();

        // start held high: back-to-back conversions every W+2 cycles.
        vals[0] = 16'd1;      vals[1] = 16'd99;
        exps[0] = 20'h00001;  exps[1] = 20'h00099;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = vals[0];
        @(posedge clk); #1;
        acc = cyc;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.bcd  = exps[i % 2];
            e.ovf4 = 1'b0;
            e.cyc  = acc + W + 1;
            sb.push_back(e);
            pushed++;
            if (i == 5) begin
                start = 1'b0;
            end else begin
                bin = vals[(i + 1) % 2];
                repeat (W + 2) @(posedge clk);
                #1;
                acc += W + 2;
            end
        end
        drain();

        repeat (W + 4) @(negedge clk);
        check("tick_count", ticks, pushed);
        check("final_ready", 32'(ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
